// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the fetch/data memory arbiter
package mem_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_DM = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// rtl/mem_arb_pick.sv - combinational 2-way grant select; MEM_ARB_RR_EN adds round-robin on conflict
module mem_arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic if_elig_i,
    input  logic dm_elig_i,
`ifdef MEM_ARB_RR_EN
    input  logic last_owner_i,
`endif
    output logic gnt_valid_o,
    output logic gnt_owner_o
);

    logic conflict_owner;

`ifdef MEM_ARB_RR_EN
    assign conflict_owner = (last_owner_i == OWNER_IF) ? OWNER_DM : OWNER_IF;
`else
    assign conflict_owner = OWNER_DM;
`endif

    always_comb begin
        gnt_valid_o = if_elig_i | dm_elig_i;
        gnt_owner_o = OWNER_IF;
        if (if_elig_i && dm_elig_i) begin
            gnt_owner_o = conflict_owner;
        end else if (dm_elig_i) begin
            gnt_owner_o = OWNER_DM;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one single-port memory between fetch and data ports, one transaction at a time
// Optional build macro: MEM_ARB_RR_EN (round-robin on conflict instead of fixed data priority).
module mem_arbiter
    import mem_arbiter_pkg::*;
(
    input  logic  i_clk,
    input  logic  i_rstn,
    input  logic  i_if_req,
    input  addr_t i_if_addr,
    output data_t o_if_rdata,
    output logic  o_if_valid,
    input  logic  i_dm_req,
    input  logic  i_dm_wen,
    input  addr_t i_dm_addr,
    input  data_t i_dm_wdata,
    output data_t o_dm_rdata,
    output logic  o_dm_valid,
    output logic  o_mem_req,
    output logic  o_mem_wen,
    output addr_t o_mem_addr,
    output data_t o_mem_wdata,
    input  logic  i_mem_gnt,
    input  logic  i_mem_rvalid,
    input  data_t i_mem_rdata,
    output logic  o_stall
);

    arb_state_t state_q, state_d;
    logic       owner_q, owner_d;
    addr_t      addr_q, addr_d;
    logic       wen_q, wen_d;
    data_t      wdata_q, wdata_d;
    data_t      if_rdata_q, if_rdata_d;
    data_t      dm_rdata_q, dm_rdata_d;
    logic       if_valid_q, if_valid_d;
    logic       dm_valid_q, dm_valid_d;
`ifdef MEM_ARB_RR_EN
    logic       last_q, last_d;
`endif

    logic if_elig, dm_elig;
    logic gnt_valid, gnt_owner;

    // A requester whose completion is pulsing this cycle still has req high; do not reissue it.
    assign if_elig = i_if_req & ~if_valid_q;
    assign dm_elig = i_dm_req & ~dm_valid_q;

    mem_arb_pick u_pick (
        .if_elig_i    (if_elig),
        .dm_elig_i    (dm_elig),
`ifdef MEM_ARB_RR_EN
        .last_owner_i (last_q),
`endif
        .gnt_valid_o  (gnt_valid),
        .gnt_owner_o  (gnt_owner)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= IDLE;
            owner_q    <= OWNER_IF;
            addr_q     <= '0;
            wen_q      <= 1'b0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
            if_valid_q <= 1'b0;
            dm_valid_q <= 1'b0;
`ifdef MEM_ARB_RR_EN
            last_q     <= OWNER_IF;
`endif
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            addr_q     <= addr_d;
            wen_q      <= wen_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
            if_valid_q <= if_valid_d;
            dm_valid_q <= dm_valid_d;
`ifdef MEM_ARB_RR_EN
            last_q     <= last_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        addr_d     = addr_q;
        wen_d      = wen_q;
        wdata_d    = wdata_q;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        if_valid_d = 1'b0;
        dm_valid_d = 1'b0;
`ifdef MEM_ARB_RR_EN
        last_d     = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    state_d = REQ;
                    owner_d = gnt_owner;
`ifdef MEM_ARB_RR_EN
                    last_d  = gnt_owner;
`endif
                    if (gnt_owner == OWNER_DM) begin
                        addr_d  = i_dm_addr;
                        wen_d   = i_dm_wen;
                        wdata_d = i_dm_wdata;
                    end else begin
                        addr_d  = i_if_addr;
                        wen_d   = 1'b0;
                        wdata_d = '0;
                    end
                end
            end
            REQ: begin
                if (i_mem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (i_mem_rvalid) begin
                    state_d = IDLE;
                    // Write acknowledgements carry no data; keep the requester's last read word.
                    if (owner_q == OWNER_DM) begin
                        dm_valid_d = 1'b1;
                        if (!wen_q) begin
                            dm_rdata_d = i_mem_rdata;
                        end
                    end else begin
                        if_valid_d = 1'b1;
                        if_rdata_d = i_mem_rdata;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_mem_req   = (state_q == REQ);
    assign o_mem_wen   = wen_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_if_rdata  = if_rdata_q;
    assign o_if_valid  = if_valid_q;
    assign o_dm_rdata  = dm_rdata_q;
    assign o_dm_valid  = dm_valid_q;
    assign o_stall     = i_if_req | i_dm_req | (state_q != IDLE);

endmodule
